// File: rtl/camera_ctrl.sv
// Pixel-array camera controller: idle/erase with exposure trim, one timed exposure, then a two-row ADC readout.
// Optional registered busy output is enabled by defining CAMERA_BUSY_EN.
module camera_ctrl #(
  parameter int EXP_W   = 5,
  parameter int EXP_MIN = 2,
  parameter int EXP_MAX = 30,
  parameter int EXP_RST = 10,
  parameter int RD_W    = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic init,
  input  logic exp_inc,
  input  logic exp_dec,
  output logic nre1,
  output logic nre2,
  output logic expose,
  output logic erase,
  output logic adc
`ifdef CAMERA_BUSY_EN
  ,
  output logic busy
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPOSE = 2'd1,
    ST_READ   = 2'd2
  } state_t;

  localparam logic [EXP_W-1:0] EXP_MIN_V = EXP_W'(EXP_MIN);
  localparam logic [EXP_W-1:0] EXP_MAX_V = EXP_W'(EXP_MAX);
  localparam logic [EXP_W-1:0] EXP_RST_V = EXP_W'(EXP_RST);
  localparam logic [RD_W-1:0]  RD_LAST   = '1;

  state_t           state_reg, state_next;
  logic [EXP_W-1:0] exp_time_reg, exp_time_next;
  logic [EXP_W-1:0] exp_count_reg, exp_count_next;
  logic [RD_W-1:0]  rd_reg, rd_next;
  logic             nre1_next, nre2_next, expose_next, erase_next, adc_next;
`ifdef CAMERA_BUSY_EN
  logic             busy_next;
`endif

  // State, counters and all outputs are registered together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      exp_time_reg  <= EXP_RST_V;
      exp_count_reg <= '0;
      rd_reg        <= '0;
      nre1          <= 1'b1;
      nre2          <= 1'b1;
      expose        <= 1'b0;
      erase         <= 1'b1;
      adc           <= 1'b0;
`ifdef CAMERA_BUSY_EN
      busy          <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      exp_time_reg  <= exp_time_next;
      exp_count_reg <= exp_count_next;
      rd_reg        <= rd_next;
      nre1          <= nre1_next;
      nre2          <= nre2_next;
      expose        <= expose_next;
      erase         <= erase_next;
      adc           <= adc_next;
`ifdef CAMERA_BUSY_EN
      busy          <= busy_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    exp_time_next  = exp_time_reg;
    exp_count_next = exp_count_reg;
    rd_next        = rd_reg;
    case (state_reg)
      ST_IDLE: begin
        // Trim is applied even on the edge that accepts init.
        if (exp_inc && !exp_dec && (exp_time_reg < EXP_MAX_V))
          exp_time_next = exp_time_reg + EXP_W'(1);
        else if (exp_dec && !exp_inc && (exp_time_reg > EXP_MIN_V))
          exp_time_next = exp_time_reg - EXP_W'(1);
        if (init) begin
          state_next     = ST_EXPOSE;
          exp_count_next = '0;
        end
      end
      ST_EXPOSE: begin
        exp_count_next = exp_count_reg + EXP_W'(1);
        if (exp_count_reg == exp_time_reg - EXP_W'(1)) begin
          state_next = ST_READ;
          rd_next    = '0;
        end
      end
      ST_READ: begin
        rd_next = rd_reg + RD_W'(1);
        if (rd_reg == RD_LAST)
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they line up with it after the edge.
  always_comb begin
    nre1_next   = 1'b1;
    nre2_next   = 1'b1;
    expose_next = 1'b0;
    erase_next  = 1'b0;
    adc_next    = 1'b0;
    case (state_next)
      ST_IDLE:   erase_next  = 1'b1;
      ST_EXPOSE: expose_next = 1'b1;
      ST_READ: begin
        nre1_next = rd_next[RD_W-1];
        nre2_next = ~rd_next[RD_W-1];
        adc_next  = rd_next[0];
      end
      default:   erase_next  = 1'b1;
    endcase
  end

`ifdef CAMERA_BUSY_EN
  always_comb begin
    busy_next = (state_next != ST_IDLE);
  end
`endif

endmodule

// File: tb/tb_camera_ctrl.sv
// Randomized self-checking bench for camera_ctrl against a frame-timeline reference model.
// Also exercises the busy output when CAMERA_BUSY_EN is defined.
module tb_camera_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic init = 1'b0;
  logic exp_inc = 1'b0;
  logic exp_dec = 1'b0;
  logic nre1, nre2, expose, erase, adc;
`ifdef CAMERA_BUSY_EN
  logic busy;
`endif

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  // Reference model: a frame is a timeline of m_len_t expose cycles followed by 4 read cycles.
  int m_exp = 10;
  bit m_busy = 1'b0;
  int m_t = 0;
  int m_len_t = 0;
  int m_starts = 0;

  camera_ctrl dut (
    .clk(clk), .reset(reset), .init(init), .exp_inc(exp_inc), .exp_dec(exp_dec),
    .nre1(nre1), .nre2(nre2), .expose(expose), .erase(erase), .adc(adc)
`ifdef CAMERA_BUSY_EN
    , .busy(busy)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, expv);
  endtask

  function automatic logic [4:0] model_outs();
    int r;
    if (!m_busy) return 5'b10110;             // {erase, expose, nre1, nre2, adc}
    if (m_t < m_len_t) return 5'b01110;
    r = m_t - m_len_t;
    return {1'b0, 1'b0, (r >= 2), (r < 2), (r % 2 == 1)};
  endfunction

  task automatic model_reset();
    m_exp = 10;
    m_busy = 1'b0;
    m_t = 0;
  endtask

  task automatic model_step();
    if (!m_busy) begin
      if (exp_inc === 1'b1 && exp_dec !== 1'b1) m_exp = (m_exp + 1 > 30) ? 30 : m_exp + 1;
      else if (exp_dec === 1'b1 && exp_inc !== 1'b1) m_exp = (m_exp - 1 < 2) ? 2 : m_exp - 1;
      if (init === 1'b1) begin
        m_busy = 1'b1;
        m_t = 0;
        m_len_t = m_exp;
        m_starts++;
      end
    end else begin
      m_t++;
      if (m_t == m_len_t + 4) m_busy = 1'b0;
    end
  endtask

  task automatic check_outputs();
    check("outs", {27'd0, erase, expose, nre1, nre2, adc}, {27'd0, model_outs()});
    check("exp_time", 32'(dut.exp_time_reg), 32'(m_exp));
    check("inv_nre", {31'd0, (nre1 | nre2)}, 32'd1);
    check("inv_exp_erase", {31'd0, ~(expose & erase)}, 32'd1);
    check("inv_adc", {31'd0, (~adc | ~nre1 | ~nre2)}, 32'd1);
`ifdef CAMERA_BUSY_EN
    check("busy", {31'd0, busy}, {31'd0, m_busy});
`endif
  endtask

  // One clock: model sees the same inputs as the DUT at the edge; outputs are checked at the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (!reset) model_reset();
    else model_step();
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  task automatic set_in(input logic i, input logic inc, input logic dec);
    init = i;
    exp_inc = inc;
    exp_dec = dec;
  endtask

  initial begin
    int rises;
    int starts0;
    logic prev_expose;
    model_reset();
    @(negedge clk);
    check_outputs();
    cycle();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // Saturation of the exposure trim in both directions, then both buttons together.
    set_in(0, 1, 0); for (int i = 0; i < 25; i++) cycle();
    check("sat_max", 32'(dut.exp_time_reg), 32'd30);
    set_in(0, 0, 1); for (int i = 0; i < 40; i++) cycle();
    check("sat_min", 32'(dut.exp_time_reg), 32'd2);
    set_in(0, 1, 1); for (int i = 0; i < 5; i++) cycle();
    set_in(0, 1, 0); for (int i = 0; i < 28; i++) cycle();

    // Full 30-cycle frame with inc/init noise during exposure and readout.
    set_in(1, 0, 0); cycle();
    for (int i = 0; i < 33; i++) begin
      set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      cycle();
    end
    set_in(0, 0, 0); for (int i = 0; i < 5; i++) cycle();

    // Asynchronous reset in the middle of an exposure.
    set_in(1, 0, 0); cycle();
    set_in(0, 0, 0); for (int i = 0; i < 5; i++) cycle();
    #1 reset = 1'b0;
    #1;
    check("async_rst_outs", {27'd0, erase, expose, nre1, nre2, adc}, 32'h16);
    check("async_rst_exp", 32'(dut.exp_time_reg), 32'd10);
    model_reset();
    cycle(); cycle();
    reset = 1'b1;
    cycle();

    // Back-to-back shortest frames with init held high.
    set_in(0, 0, 1); for (int i = 0; i < 10; i++) cycle();
    set_in(1, 0, 0);
    rises = 0;
    starts0 = m_starts;
    prev_expose = expose;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (expose && !prev_expose) rises++;
      prev_expose = expose;
    end
    check("held_frames", 32'(rises), 32'(m_starts - starts0));
    check("held_frames_n", 32'(rises), 32'd15);
    set_in(0, 0, 0); for (int i = 0; i < 5; i++) cycle();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
